// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one fixed-latency single-ported memory between the
// instruction-fetch and data requesters; data has priority with starvation
// protection for fetch. MEM_ARB_PERF_EN adds per-port wait-cycle counters.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       if_wait_cnt,
    output logic [15:0]       d_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_lat_init   = 4'(MEM_LAT - 1);
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the transaction
    logic              store_q, store_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              grant_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        store_d      = store_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        grant_data   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    grant_data = d_req && !(if_req && (starve_cnt_q == c_starve_max));
                    owner_d    = grant_data;
                    store_d    = grant_data && d_we;
                    mem_en_d   = 1'b1;
                    mem_we_d   = grant_data && d_we;
                    if (grant_data) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (!if_req) begin
                            starve_cnt_d = 4'd0;
                        end else if (starve_cnt_q != c_starve_max) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else begin
                        mem_addr_d   = if_addr;
                        starve_cnt_d = 4'd0;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (store_q) begin
                    d_ack_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = c_lat_init;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    if (owner_q) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            store_q      <= 1'b0;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            store_q      <= store_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign stall_mem = d_req & ~d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] if_wait_cnt_q, if_wait_cnt_d;
    logic [15:0] d_wait_cnt_q, d_wait_cnt_d;

    always_comb begin
        if_wait_cnt_d = if_wait_cnt_q;
        d_wait_cnt_d  = d_wait_cnt_q;
        if (if_req && !if_ack_q && (if_wait_cnt_q != 16'hFFFF)) begin
            if_wait_cnt_d = if_wait_cnt_q + 16'd1;
        end
        if (d_req && !d_ack_q && (d_wait_cnt_q != 16'hFFFF)) begin
            d_wait_cnt_d = d_wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            if_wait_cnt_q <= 16'd0;
            d_wait_cnt_q  <= 16'd0;
        end else begin
            if_wait_cnt_q <= if_wait_cnt_d;
            d_wait_cnt_q  <= d_wait_cnt_d;
        end
    end

    assign if_wait_cnt = if_wait_cnt_q;
    assign d_wait_cnt  = d_wait_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported external memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage load/store).
- Serialises transactions through a fixed-latency memory with a small FSM.
- Returns read data and a one-cycle ack to each requester, and produces stall signals for the pipeline.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from memory enable to valid mem_rdata (legal range 1..15).
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before IF is forced (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched word; valid when if_ack, held until next IF ack
- if_ack  out  1  one-cycle completion pulse for IF
- stall_if  out  1  if_req & ~if_ack (combinational)
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when d_ack on a load, held until next data-load ack
- d_ack  out  1  one-cycle completion pulse for data
- stall_mem  out  1  d_req & ~d_ack (combinational)
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE; all outputs 0; rdata registers 0; starve_cnt=0; lat_cnt=0.
- Reset mid-transaction: the transaction is dropped and no ack is issued. mem_en and mem_we fall immediately. Requesters reissue after reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate on registered decision.
  - Only d_req → owner=D.
  - Only if_req → owner=IF.
  - Both → owner=D, unless starve_cnt==STARVE_MAX, then owner=IF.
  - Latch owner, address, we and wdata; go to ISSUE. No request → stay in IDLE.
- ISSUE (1 cycle): mem_en=1, mem_addr/mem_we/mem_wdata from latched values.
  - Store → RESP.
  - Load or fetch → WAIT with lat_cnt=MEM_LAT-1.
- WAIT: lat_cnt decrements each cycle. When lat_cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
  - MEM_LAT=1 means WAIT lasts one cycle, with capture in that cycle.
- RESP (1 cycle): pulse owner's ack; rdata is already stable. Return to IDLE. Requests are ignored during RESP, so the next grant is evaluated the cycle after the ack.
- Latency, req sampled at cycle T in IDLE:
  - Load/fetch: ack at T+MEM_LAT+2.
  - Store: ack at T+2.
- Fetch is read-only; IF never drives mem_we=1.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each D grant made while if_req=1.
  - Clears to 0 on any IF grant.
  - Clears to 0 on a D grant made with if_req=0.
- mem_en is asserted only in ISSUE. mem_addr, mem_wdata and mem_we hold the last latched values otherwise; mem_we is forced 0 outside ISSUE.
- A requester dropping req before its ack is a protocol violation. The transaction still completes and the ack is still pulsed.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds outputs if_wait_cnt[15:0] and d_wait_cnt[15:0].
  - Each counts cycles where its req=1 and ack=0.
  - Saturates at 16'hFFFF.
  - Clears on clr.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Lone fetch, MEM_LAT=2, if_req=1 at cycle 0, mem_rdata=32'hDEADBEEF at cycle 3 → mem_en=1 at cycle 1, we=0; if_ack at cycle 4 with if_rdata=32'hDEADBEEF; stall_if=1 at cycles 0–3.
- Lone store, d_addr=32'h10, d_wdata=32'h55 at cycle 0 → cycle 1: mem_en=1, mem_we=1, addr 32'h10, wdata 32'h55; d_ack at cycle 2; d_rdata unchanged.
- Simultaneous if_req and d_req (load) at cycle 0 → data served first (d_ack at cycle 4); IF granted at cycle 5, if_ack at cycle 9.
- Starvation: if_req held high, d_req continuously reissued, STARVE_MAX=4 → exactly 4 data acks, then the IF ack, then data resumes; starve_cnt back to 0.
- Assert clr during WAIT of a fetch → mem_en, if_ack and if_rdata are 0 immediately; after release with if_req still 1, the fetch restarts and completes with the full MEM_LAT+2 latency.
- MEM_ARB_PERF_EN defined; the simultaneous scenario above → if_wait_cnt=9, d_wait_cnt=4.
